reg_writeback_unit: RTL and testbench

- Write-side initiator for the 4×16-bit register file.
- Merges results from two producers onto the file's single write port: an ALU that is never stalled, and a memory-load path with valid/ready handshake.
- Buffers load results in a 2-entry FIFO and drives registered `RegWrite`/`RD`/`WriteData`.
- Publishes a per-register pending scoreboard that decode uses for load-use hazard stalls.

---
 rtl/reg_writeback_unit_if.sv | 36 +++
 rtl/reg_writeback_unit.sv | 128 ++++++++++++
 tb/tb_reg_writeback_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_writeback_unit_if.sv
// rtl/reg_writeback_unit_if.sv - producer and register-file write port bundle for reg_writeback_unit
// master: the writeback unit; slave: producers, register file and decode.

interface reg_writeback_unit_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
);
    logic                     AluValid;
    logic [ADDR_W-1:0]        AluRD;
    logic [DATA_W-1:0]        AluData;
    logic                     MemValid;
    logic                     MemReady;
    logic [ADDR_W-1:0]        MemRD;
    logic [DATA_W-1:0]        MemData;
    logic                     RegWrite;
    logic [ADDR_W-1:0]        RD;
    logic [DATA_W-1:0]        WriteData;
    logic [(1<<ADDR_W)-1:0]   Pending;
    logic [15:0]              StallCount;

    modport master (
        input  AluValid, AluRD, AluData,
        input  MemValid, MemRD, MemData,
        output MemReady,
        output RegWrite, RD, WriteData,
        output Pending, StallCount
    );

    modport slave (
        output AluValid, AluRD, AluData,
        output MemValid, MemRD, MemData,
        input  MemReady,
        input  RegWrite, RD, WriteData,
        input  Pending, StallCount
    );
endinterface

// File: rtl/reg_writeback_unit.sv
// rtl/reg_writeback_unit.sv - merges ALU and load results onto the register-file write port
// Optional stall statistic built when REG_WRITEBACK_STATS_EN is defined.

module reg_writeback_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 2
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    reg_writeback_unit_if.master wb
);
    localparam int NREG = 1 << ADDR_W;

    // Two-entry circular load FIFO; a killed entry still occupies its slot until popped.
    logic [1:0]        count_q;
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic [DEPTH-1:0]  ent_valid_q;
    logic [DEPTH-1:0]  ent_killed_q;
    logic [ADDR_W-1:0] ent_rd_q   [DEPTH];
    logic [DATA_W-1:0] ent_data_q [DEPTH];

    logic              regwrite_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] wdata_q;
    logic [NREG-1:0]   pending;

    logic fifo_nonempty;
    logic mem_ready;
    logic push;
    logic pop;
    logic push_killed;

    assign fifo_nonempty = (count_q != 2'd0);
    assign mem_ready     = ResetN & (count_q != 2'(DEPTH));
    assign push          = wb.MemValid & mem_ready;
    assign pop           = ~wb.AluValid & fifo_nonempty;
    // A same-edge ALU result to the same register is younger, so the load is born dead.
    assign push_killed   = wb.AluValid & (wb.MemRD == wb.AluRD);

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            count_q      <= 2'd0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            ent_valid_q  <= '0;
            ent_killed_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_rd_q[i]   <= '0;
                ent_data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb.AluValid && ent_valid_q[i] && (ent_rd_q[i] == wb.AluRD)) begin
                    ent_killed_q[i] <= 1'b1;
                end
            end
            if (pop) begin
                ent_valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q              <= ~rd_ptr_q;
            end
            if (push) begin
                ent_valid_q[wr_ptr_q]  <= 1'b1;
                ent_killed_q[wr_ptr_q] <= push_killed;
                ent_rd_q[wr_ptr_q]     <= wb.MemRD;
                ent_data_q[wr_ptr_q]   <= wb.MemData;
                wr_ptr_q               <= ~wr_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            wdata_q    <= '0;
        end else if (wb.AluValid) begin
            regwrite_q <= 1'b1;
            rd_q       <= wb.AluRD;
            wdata_q    <= wb.AluData;
        end else if (fifo_nonempty) begin
            regwrite_q <= ~ent_killed_q[rd_ptr_q];
            rd_q       <= ent_rd_q[rd_ptr_q];
            wdata_q    <= ent_data_q[rd_ptr_q];
        end else begin
            regwrite_q <= 1'b0;
        end
    end

    always_comb begin
        pending = '0;
        for (int r = 0; r < NREG; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_valid_q[i] && !ent_killed_q[i] && (ent_rd_q[i] == ADDR_W'(r))) begin
                    pending[r] = 1'b1;
                end
            end
        end
    end

`ifdef REG_WRITEBACK_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            stall_q <= 16'd0;
        end else if (fifo_nonempty && wb.AluValid && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign wb.StallCount = stall_q;
`else
    assign wb.StallCount = 16'd0;
`endif

    assign wb.MemReady  = mem_ready;
    assign wb.RegWrite  = regwrite_q;
    assign wb.RD        = rd_q;
    assign wb.WriteData = wdata_q;
    assign wb.Pending   = pending;
endmodule

// File: tb/tb_reg_writeback_unit.sv
// tb/tb_reg_writeback_unit.sv - directed scoreboard bench for reg_writeback_unit
// Expected StallCount follows REG_WRITEBACK_STATS_EN.

module tb_reg_writeback_unit;
    logic Clock;
    logic ResetN;

    reg_writeback_unit_if #(.DATA_W(16), .ADDR_W(2)) bus ();

    reg_writeback_unit #(.DATA_W(16), .ADDR_W(2), .DEPTH(2)) dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .wb     (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int compared   = 0;
    int mismatched = 0;

    logic [17:0] alu_q  [$];
    logic [17:0] load_q [$];
    logic [15:0] rf [4];

    always @(posedge Clock) begin
        if (bus.RegWrite) rf[bus.RD] <= bus.WriteData;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [1:0] ard, input logic [15:0] ad,
                         input logic mv, input logic [1:0] mrd, input logic [15:0] md,
                         input logic mexp);
        bus.AluValid = av;
        bus.AluRD    = ard;
        bus.AluData  = ad;
        bus.MemValid = mv;
        bus.MemRD    = mrd;
        bus.MemData  = md;
        if (av) alu_q.push_back({ard, ad});
        if (mv && mexp) load_q.push_back({mrd, md});
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 16'd0, 1'b0, 2'd0, 16'd0, 1'b0);
    endtask

    // Advance one edge and score any register-file write it produced.
    task automatic tick();
        logic a_at;
        logic rst_at;
        logic [17:0] exp;
        a_at   = bus.AluValid;
        rst_at = ResetN;
        @(posedge Clock);
        #1;
        if (rst_at && ResetN) begin
            if (a_at) check("alu_regwrite", {31'd0, bus.RegWrite}, 32'd1);
            if (bus.RegWrite) begin
                if (a_at ? (alu_q.size() == 0) : (load_q.size() == 0)) begin
                    check("unexpected_write", {14'd0, bus.RD, bus.WriteData}, 32'hFFFFFFFF);
                end else begin
                    exp = a_at ? alu_q.pop_front() : load_q.pop_front();
                    check(a_at ? "alu_write" : "load_write",
                          {14'd0, bus.RD, bus.WriteData}, {14'd0, exp});
                end
            end
        end
    endtask

    initial begin
        ResetN = 1'b0;
        bus.AluValid = 1'b0; bus.AluRD = '0; bus.AluData = '0;
        bus.MemValid = 1'b0; bus.MemRD = '0; bus.MemData = '0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            bus.AluValid = 1'($urandom);
            bus.AluRD    = 2'($urandom);
            bus.AluData  = 16'($urandom);
            bus.MemValid = 1'($urandom);
            bus.MemRD    = 2'($urandom);
            bus.MemData  = 16'($urandom);
            tick();
            check("rst_regwrite", {31'd0, bus.RegWrite}, 32'd0);
            check("rst_pending", {28'd0, bus.Pending}, 32'd0);
            check("rst_memready", {31'd0, bus.MemReady}, 32'd0);
        end
        check("rst_rd", {30'd0, bus.RD}, 32'd0);
        check("rst_wdata", {16'd0, bus.WriteData}, 32'd0);
        check("rst_stall", {16'd0, bus.StallCount}, 32'd0);
        idle();
        ResetN = 1'b1;
        #1;
        check("release_memready", {31'd0, bus.MemReady}, 32'd1);
        tick();
        check("release_no_write", {31'd0, bus.RegWrite}, 32'd0);

        // ALU write
        drive(1'b1, 2'd2, 16'd7, 1'b0, 2'd0, 16'd0, 1'b0);
        tick();
        idle();
        tick();
        check("rf2_alu", {16'd0, rf[2]}, 32'd7);

        // Two loads stuck behind three ALU cycles, then drain in order
        drive(1'b1, 2'd2, 16'h0021, 1'b1, 2'd1, 16'd5, 1'b1);
        tick();
        check("one_pending", {28'd0, bus.Pending}, 32'b0010);
        drive(1'b1, 2'd2, 16'h0022, 1'b1, 2'd3, 16'd9, 1'b1);
        tick();
        check("full_pending", {28'd0, bus.Pending}, 32'b1010);
        check("full_memready", {31'd0, bus.MemReady}, 32'd0);
        drive(1'b1, 2'd2, 16'h0023, 1'b1, 2'd0, 16'hBEEF, 1'b0);
        tick();
        check("full_pending2", {28'd0, bus.Pending}, 32'b1010);
        check("full_memready2", {31'd0, bus.MemReady}, 32'd0);
        idle();
        tick();
        check("drain1_pending", {28'd0, bus.Pending}, 32'b1000);
        check("drain1_memready", {31'd0, bus.MemReady}, 32'd1);
        tick();
        check("drain2_pending", {28'd0, bus.Pending}, 32'b0000);
        tick();
        check("rf1_load", {16'd0, rf[1]}, 32'd5);
        check("rf3_load", {16'd0, rf[3]}, 32'd9);

        // WAW kill of a queued load
        drive(1'b0, 2'd0, 16'd0, 1'b1, 2'd0, 16'hAAAA, 1'b0);
        tick();
        check("waw_pending_set", {28'd0, bus.Pending}, 32'b0001);
        drive(1'b1, 2'd0, 16'h1234, 1'b0, 2'd0, 16'd0, 1'b0);
        tick();
        check("waw_pending_clr", {28'd0, bus.Pending}, 32'b0000);
        idle();
        tick();
        check("waw_kill_slot", {31'd0, bus.RegWrite}, 32'd0);
        tick();
        check("rf0_waw", {16'd0, rf[0]}, 32'h1234);

        // Same-edge ALU and load to the same register
        drive(1'b1, 2'd1, 16'h0055, 1'b1, 2'd1, 16'h0066, 1'b0);
        tick();
        check("same_edge_pending", {28'd0, bus.Pending}, 32'b0000);
        idle();
        tick();
        check("same_edge_kill_slot", {31'd0, bus.RegWrite}, 32'd0);

        // Pop and enqueue on the same edge at count 1
        drive(1'b0, 2'd0, 16'd0, 1'b1, 2'd2, 16'h0100, 1'b1);
        tick();
        check("popenq_pending0", {28'd0, bus.Pending}, 32'b0100);
        drive(1'b0, 2'd0, 16'd0, 1'b1, 2'd3, 16'h0200, 1'b1);
        tick();
        check("popenq_pending1", {28'd0, bus.Pending}, 32'b1000);
        check("popenq_memready", {31'd0, bus.MemReady}, 32'd1);
        idle();
        tick();
        check("popenq_pending2", {28'd0, bus.Pending}, 32'b0000);
        tick();
        check("popenq_idle", {31'd0, bus.RegWrite}, 32'd0);

        // Mid-operation reset discards a queued load
        drive(1'b0, 2'd0, 16'd0, 1'b1, 2'd3, 16'hDEAD, 1'b0);
        tick();
        check("pre_rst_pending", {28'd0, bus.Pending}, 32'b1000);
        idle();
        ResetN = 1'b0;
        #1;
        check("async_rst_pending", {28'd0, bus.Pending}, 32'd0);
        check("async_rst_memready", {31'd0, bus.MemReady}, 32'd0);
        check("async_rst_regwrite", {31'd0, bus.RegWrite}, 32'd0);
        tick();
        ResetN = 1'b1;
        tick();
        tick();
        check("post_rst_stall", {16'd0, bus.StallCount}, 32'd0);
        check("rf3_kept", {16'd0, rf[3]}, 32'h0200);

        // Stall statistic: four ALU edges with a non-empty FIFO
        drive(1'b0, 2'd0, 16'd0, 1'b1, 2'd1, 16'h0077, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd2, 16'(16'h0031 + i), 1'b0, 2'd0, 16'd0, 1'b0);
            tick();
        end
`ifdef REG_WRITEBACK_STATS_EN
        check("stall_count", {16'd0, bus.StallCount}, 32'd4);
`else
        check("stall_count", {16'd0, bus.StallCount}, 32'd0);
`endif
        idle();
        tick();
        tick();
        check("rf1_stalled_load", {16'd0, rf[1]}, 32'h0077);
        check("rf2_last_alu", {16'd0, rf[2]}, 32'h0034);

        check("alu_q_empty", alu_q.size(), 32'd0);
        check("load_q_empty", load_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
